// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the button-stepped 8-bit Fibonacci LFSR.
package lfsr_pkg;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAP = 8'b0001_1101;

  // Width that can hold 0..db_cycles inclusive.
  function automatic int db_cnt_w(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

  // One shift-right step; an all-zero state would otherwise lock up, so it is forced to 1.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    if (q == '0) return {{(LFSR_W-1){1'b0}}, 1'b1};
    return {^(q & TAP), q[LFSR_W-1:1]};
  endfunction
endpackage

// File: rtl/lfsr_stepper_btn_debounce.sv
// Two-flop synchronizer plus stable-sample counter; rise strikes on the edge the level flips to 1.
module btn_debounce
  import lfsr_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);
  localparam int CW = db_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          differ, hit;

  always_comb begin
    sync_d  = {sync_q[0], btn};
    differ  = sync_q[1] ^ level_q;
    // Flip on the edge the counter would reach DB_CYCLES.
    hit     = differ && (cnt_q == LAST);
    cnt_d   = (differ && !hit) ? cnt_q + CW'(1) : '0;
    level_d = hit ? ~level_q : level_q;
    rise    = hit && !level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
endmodule

// File: rtl/lfsr_stepper.sv
// 8-bit LFSR advanced once per debounced button press, with parallel load and step counter.
module lfsr_stepper
  import lfsr_pkg::*;
#(
  parameter int                DB_CYCLES = 16,
  parameter logic [LFSR_W-1:0] SEED      = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q,
  output logic [3:0]        hi_code,
  output logic [3:0]        lo_code,
  output logic              step_pulse,
  output logic [7:0]        step_cnt
);
  logic [LFSR_W-1:0] q_q, q_d;
  logic [7:0]        step_cnt_q, step_cnt_d;
  logic              step_pulse_q, step_pulse_d;
  logic              db_level, db_rise;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_step),
    .level(db_level),
    .rise (db_rise)
  );

  // Load wins over a coinciding step; that step is dropped entirely.
  always_comb begin
    q_d          = q_q;
    step_cnt_d   = step_cnt_q;
    step_pulse_d = 1'b0;
    if (load) begin
      q_d        = load_val;
      step_cnt_d = '0;
    end else if (db_rise) begin
      q_d          = lfsr_next(q_q);
      step_cnt_d   = step_cnt_q + 8'd1;
      step_pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q          <= SEED;
      step_cnt_q   <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      step_cnt_q   <= step_cnt_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign q          = q_q;
  assign hi_code    = q_q[7:4];
  assign lo_code    = q_q[3:0];
  assign step_pulse = step_pulse_q;
  assign step_cnt   = step_cnt_q;
endmodule
